// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter: master ids and the
// request bundle each master presents to the bus.
package mem_bus_pkg;

   typedef logic master_id_t;

   localparam master_id_t MASTER_CPU = 1'b0;
   localparam master_id_t MASTER_AUX = 1'b1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] write_data;
      logic [3:0]  byte_enable;
      logic        write_req;
      logic        read_req;
   } bus_req_t;

endpackage

// File: rtl/read_tag_fifo.sv
// Small FIFO holding the issuing master id of each accepted read, so that
// in-order returns can be steered back to the right requester.
module read_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the CPU and an auxiliary
// master; grants are held until accepted and read returns follow a tag FIFO.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_write_data,
   input  logic [3:0]  m0_byte_enable,
   input  logic        m0_write_req,
   input  logic        m0_read_req,
   output logic        m0_ready,
   output logic [31:0] m0_read_data,
   output logic        m0_read_data_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_write_data,
   input  logic [3:0]  m1_byte_enable,
   input  logic        m1_write_req,
   input  logic        m1_read_req,
   output logic        m1_ready,
   output logic [31:0] m1_read_data,
   output logic        m1_read_data_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_write_data,
   output logic [3:0]  s_byte_enable,
   output logic        s_write_req,
   output logic        s_read_req,
   input  logic        s_ready,
   input  logic [31:0] s_read_data,
   input  logic        s_read_data_valid,
   output logic        error
);

   bus_req_t   m0_req, m1_req, s_req;
   logic       req0, req1;
   logic       has_grant, granted_req, blocked, accepted;
   master_id_t grant;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [0:0] fifo_head;
   master_id_t head_id;

   master_id_t prio_q, prio_d;
   logic       lock_valid_q, lock_valid_d;
   master_id_t lock_id_q, lock_id_d;
   logic       error_q, error_d;

   assign m0_req = '{addr: m0_addr, write_data: m0_write_data, byte_enable: m0_byte_enable,
                     write_req: m0_write_req, read_req: m0_read_req};
   assign m1_req = '{addr: m1_addr, write_data: m1_write_data, byte_enable: m1_byte_enable,
                     write_req: m1_write_req, read_req: m1_read_req};
   assign req0   = m0_read_req || m0_write_req;
   assign req1   = m1_read_req || m1_write_req;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      has_grant = 1'b1;
      grant     = MASTER_CPU;
      if (lock_valid_q)      grant = lock_id_q;
      else if (req0 && req1) grant = prio_q;
      else if (req1)         grant = MASTER_AUX;
      else if (!req0)        has_grant = 1'b0;

      s_req = '0;
      if (has_grant) s_req = (grant == MASTER_AUX) ? m1_req : m0_req;

      granted_req = s_req.read_req || s_req.write_req;
      blocked     = s_req.read_req && fifo_full;
      accepted    = granted_req && s_ready && !blocked;
   end

   assign s_addr        = s_req.addr;
   assign s_write_data  = s_req.write_data;
   assign s_byte_enable = s_req.byte_enable;
   assign s_write_req   = s_req.write_req;
   assign s_read_req    = s_req.read_req;

   assign m0_ready = granted_req && (grant == MASTER_CPU) && s_ready && !blocked;
   assign m1_ready = granted_req && (grant == MASTER_AUX) && s_ready && !blocked;

   assign fifo_push = accepted && s_req.read_req;
   assign fifo_pop  = s_read_data_valid && !fifo_empty;
   assign head_id   = master_id_t'(fifo_head);

   assign m0_read_data       = s_read_data;
   assign m1_read_data       = s_read_data;
   assign m0_read_data_valid = fifo_pop && (head_id == MASTER_CPU);
   assign m1_read_data_valid = fifo_pop && (head_id == MASTER_AUX);
   assign error              = error_q;

   read_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_tag_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (grant),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A locked master that withdraws its request is a protocol violation.
   always_comb begin
      prio_d       = accepted ? ~grant : prio_q;
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      error_d      = error_q || (s_read_data_valid && fifo_empty);
      if (lock_valid_q) begin
         if (!granted_req) begin
            lock_valid_d = 1'b0;
            error_d      = 1'b1;
         end else if (accepted) begin
            lock_valid_d = 1'b0;
         end
      end else if (granted_req && !accepted) begin
         lock_valid_d = 1'b1;
         lock_id_d    = grant;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_q       <= MASTER_CPU;
         lock_valid_q <= 1'b0;
         lock_id_q    <= MASTER_CPU;
         error_q      <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         error_q      <= error_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; a queue of expected return owners is
// filled on accepted reads and drained when returns are driven.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
   logic [3:0]  m0_byte_enable, m1_byte_enable;
   logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
   logic        m0_ready, m1_ready, m0_read_data_valid, m1_read_data_valid;
   logic [31:0] m0_read_data, m1_read_data;
   logic [31:0] s_addr, s_write_data, s_read_data;
   logic [3:0]  s_byte_enable;
   logic        s_write_req, s_read_req, s_ready, s_read_data_valid, error;

   int errors = 0;
   int checks = 0;
   bit exp_owner_q[$];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
      .clk (clk), .reset_n (reset_n),
      .m0_addr (m0_addr), .m0_write_data (m0_write_data), .m0_byte_enable (m0_byte_enable),
      .m0_write_req (m0_write_req), .m0_read_req (m0_read_req), .m0_ready (m0_ready),
      .m0_read_data (m0_read_data), .m0_read_data_valid (m0_read_data_valid),
      .m1_addr (m1_addr), .m1_write_data (m1_write_data), .m1_byte_enable (m1_byte_enable),
      .m1_write_req (m1_write_req), .m1_read_req (m1_read_req), .m1_ready (m1_ready),
      .m1_read_data (m1_read_data), .m1_read_data_valid (m1_read_data_valid),
      .s_addr (s_addr), .s_write_data (s_write_data), .s_byte_enable (s_byte_enable),
      .s_write_req (s_write_req), .s_read_req (s_read_req), .s_ready (s_ready),
      .s_read_data (s_read_data), .s_read_data_valid (s_read_data_valid), .error (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_addr = '0; m0_write_data = '0; m0_byte_enable = '0; m0_write_req = 0; m0_read_req = 0;
      m1_addr = '0; m1_write_data = '0; m1_byte_enable = '0; m1_write_req = 0; m1_read_req = 0;
      s_ready = 0; s_read_data = '0; s_read_data_valid = 0;
   endtask

   // Advance one cycle; inputs change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      exp_owner_q.delete();
      tick();
      reset_n = 1'b1;
   endtask

   // Drive a return, then compare the strobes with the scoreboard head.
   task automatic do_return(input string tag, input logic [31:0] data);
      bit owner;
      s_read_data       = data;
      s_read_data_valid = 1'b1;
      #1;
      if (exp_owner_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         owner = exp_owner_q.pop_front();
         check({tag, "_m0_valid"}, {31'd0, m0_read_data_valid}, {31'd0, owner == 1'b0});
         check({tag, "_m1_valid"}, {31'd0, m1_read_data_valid}, {31'd0, owner == 1'b1});
         check({tag, "_data"}, owner ? m1_read_data : m0_read_data, data);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      #1;
      check("reset_error", {31'd0, error}, 32'd0);
      check("reset_s_read_req", {31'd0, s_read_req}, 32'd0);
      check("reset_s_addr", s_addr, 32'd0);
      apply_reset();

      // Single m0 read, return two cycles later.
      m0_addr = 32'h1000_0000; m0_read_req = 1; s_ready = 1;
      #1;
      check("t1_s_read_req", {31'd0, s_read_req}, 32'd1);
      check("t1_s_addr", s_addr, 32'h1000_0000);
      check("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
      check("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
      if (m0_ready) exp_owner_q.push_back(1'b0);
      tick();
      idle_inputs();
      tick();
      do_return("t1_ret", 32'h0000_0013);
      tick();
      idle_inputs();

      // Both masters write every cycle: grants alternate from master 0.
      apply_reset();
      begin
         bit exp_g = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m0_addr = 32'h0000_00A0; m0_write_req = 1; m0_byte_enable = 4'hF;
            m1_addr = 32'h0000_00B0; m1_write_req = 1; m1_byte_enable = 4'hF;
            s_ready = 1;
            #1;
            check($sformatf("t2_addr_%0d", i), s_addr, exp_g ? 32'h0000_00B0 : 32'h0000_00A0);
            check($sformatf("t2_m0_ready_%0d", i), {31'd0, m0_ready}, {31'd0, !exp_g});
            check($sformatf("t2_m1_ready_%0d", i), {31'd0, m1_ready}, {31'd0, exp_g});
            exp_g = ~exp_g;
            tick();
         end
      end
      idle_inputs();

      // One m0 write moves priority to m1, then m1 stalls for 3 cycles.
      m0_addr = 32'h0000_0300; m0_write_req = 1; s_ready = 1;
      #1;
      check("t3_pre_m0_ready", {31'd0, m0_ready}, 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h0000_0300; m0_write_data = 32'h1111_1111; m0_byte_enable = 4'h3; m0_write_req = 1;
         m1_addr = 32'h0000_0200; m1_write_data = 32'hDEAD_BEEF; m1_byte_enable = 4'hF; m1_write_req = 1;
         s_ready = (i == 3);
         #1;
         check($sformatf("t3_addr_%0d", i), s_addr, 32'h0000_0200);
         check($sformatf("t3_wdata_%0d", i), s_write_data, 32'hDEAD_BEEF);
         check($sformatf("t3_be_%0d", i), {28'd0, s_byte_enable}, 32'hF);
         check($sformatf("t3_m0_ready_%0d", i), {31'd0, m0_ready}, 32'd0);
         check($sformatf("t3_m1_ready_%0d", i), {31'd0, m1_ready}, {31'd0, i == 3});
         tick();
      end
      m1_write_req = 0;
      #1;
      check("t3_after_addr", s_addr, 32'h0000_0300);
      check("t3_after_m0_ready", {31'd0, m0_ready}, 32'd1);
      tick();
      idle_inputs();

      // Fill the tag FIFO with four m0 reads; m1 read blocks, m1 write does not.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h0000_1000 + 32'(4 * i); m0_read_req = 1; s_ready = 1;
         #1;
         check($sformatf("t4_fill_ready_%0d", i), {31'd0, m0_ready}, 32'd1);
         if (m0_ready) exp_owner_q.push_back(1'b0);
         tick();
      end
      idle_inputs();
      m1_addr = 32'h0000_2000; m1_write_req = 1; s_ready = 1;
      #1;
      check("t4_full_write_ready", {31'd0, m1_ready}, 32'd1);
      check("t4_full_write_req", {31'd0, s_write_req}, 32'd1);
      tick();
      m1_write_req = 0; m1_read_req = 1; m1_addr = 32'h0000_2004;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("t4_blocked_ready_%0d", i), {31'd0, m1_ready}, 32'd0);
         check($sformatf("t4_blocked_rreq_%0d", i), {31'd0, s_read_req}, 32'd1);
         tick();
      end
      do_return("t4_pop_while_full", 32'h0000_00C0);
      check("t4_full_blocks_with_pop", {31'd0, m1_ready}, 32'd0);
      tick();
      s_read_data_valid = 0;
      #1;
      check("t4_unblocked_ready", {31'd0, m1_ready}, 32'd1);
      if (m1_ready) exp_owner_q.push_back(1'b1);
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         do_return($sformatf("t4_drain_%0d", i), 32'h0000_00D0 + 32'(i));
         tick();
      end
      idle_inputs();
      check("t4_no_error", {31'd0, error}, 32'd0);

      // Interleaved reads m0, m1, m0 return in issue order.
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         s_ready = 1;
         if (i == 1) begin m1_addr = 32'h0000_5000; m1_read_req = 1; end
         else begin m0_addr = 32'h0000_4000 + 32'(i); m0_read_req = 1; end
         #1;
         check($sformatf("t5_ready_%0d", i), {31'd0, (i == 1) ? m1_ready : m0_ready}, 32'd1);
         exp_owner_q.push_back(i == 1);
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         do_return($sformatf("t5_ret_%0d", i), 32'h0000_0E00 + 32'(i));
         tick();
      end
      idle_inputs();
      check("t5_no_error", {31'd0, error}, 32'd0);

      // Stray return sets a sticky error; reset clears it.
      s_read_data_valid = 1; s_read_data = 32'h0000_0BAD;
      #1;
      check("t6_stray_m0_valid", {31'd0, m0_read_data_valid}, 32'd0);
      check("t6_stray_m1_valid", {31'd0, m1_read_data_valid}, 32'd0);
      tick();
      idle_inputs();
      check("t6_error_set", {31'd0, error}, 32'd1);
      tick();
      tick();
      check("t6_error_sticky", {31'd0, error}, 32'd1);
      apply_reset();
      #1;
      check("t6_error_cleared", {31'd0, error}, 32'd0);
      m0_addr = 32'h0000_00A0; m0_write_req = 1;
      m1_addr = 32'h0000_00B0; m1_write_req = 1; s_ready = 1;
      #1;
      check("t6_prio_reset", s_addr, 32'h0000_00A0);
      tick();
      idle_inputs();
      s_read_data_valid = 1;
      #1;
      check("t6_fifo_empty_valid", {31'd0, m0_read_data_valid | m1_read_data_valid}, 32'd0);
      tick();
      idle_inputs();
      check("t6_error_again", {31'd0, error}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one system memory bus between two bus masters: master 0 is the CPU core, master 1 is a secondary requester (boot loader / DMA).
- Both sides use the same bus protocol: addr, write_data, byte_enable, write_req, read_req, ready, read_data, read_data_valid.
- Arbitrates round-robin, holds each grant until its request is accepted, and routes in-order read returns back to the issuing master using a tag FIFO.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m0_addr / m1_addr  in  32  master byte address
- m0_write_data / m1_write_data  in  32  master write data
- m0_byte_enable / m1_byte_enable  in  4  master byte lanes
- m0_write_req / m1_write_req  in  1  master write request
- m0_read_req / m1_read_req  in  1  master read request
- m0_ready / m1_ready  out  1  request accepted this cycle
- m0_read_data / m1_read_data  out  32  copy of s_read_data
- m0_read_data_valid / m1_read_data_valid  out  1  read return for this master
- s_addr, s_write_data, s_byte_enable, s_write_req, s_read_req  out  32/32/4/1/1  request to memory
- s_ready  in  1  memory accepts request
- s_read_data  in  32  memory return data
- s_read_data_valid  in  1  return strobe, in request order
- error  out  1  sticky protocol error

Behaviour:
- Requests and acceptance:
  - Master n is requesting when mn_read_req or mn_write_req is high; a master never drives both high at once.
  - A request is accepted in a cycle where it is granted, s_ready=1 and it is not blocked.
  - Zero latency: the s_* request outputs are a combinational mux of the granted master.
  - With no grant, s_addr, s_write_data, s_byte_enable = 0 and s_write_req = s_read_req = 0.
- Registered state:
  - prio: 1 bit, the master with priority next; reset 0.
  - lock_valid, lock_id: reset 0, 0.
  - tag FIFO: reset empty.
  - error: reset 0.
- Grant:
  - If lock_valid, grant lock_id.
  - Otherwise, if only one master is requesting, grant it.
  - Otherwise, if both are requesting, grant prio.
- Lock:
  - Set lock_valid=1 and lock_id=grant when a granted request is not accepted.
  - Clear lock_valid when the locked request is accepted.
  - Guarantees the s_* outputs stay stable while the memory is stalled.
- Priority: on every accepted request, prio <= ~grant.
- Blocking: a read is blocked when the FIFO is full.
  - A full FIFO blocks the push even if a pop occurs in the same cycle.
  - Writes are never blocked.
  - A blocked read still holds the lock.
- Ready outputs:
  - mn_ready = (grant==n) && s_ready && !blocked.
  - For the non-granted master, mn_ready = 0.
- Tag FIFO:
  - Push the grant id on every accepted read.
  - Pop on s_read_data_valid.
  - A simultaneous push and pop when not full keeps occupancy unchanged.
- Return routing:
  - mn_read_data = s_read_data for both masters, always.
  - mn_read_data_valid = s_read_data_valid && FIFO head == n.
- Error:
  - Set when s_read_data_valid arrives while the FIFO is empty; no pop occurs.
  - Also set when a master drops its request while locked and unaccepted; clear the lock in that case.
  - Cleared only by reset.
- Reset mid-operation:
  - All state returns to reset values; outstanding tags are discarded.
  - Later stray returns set error.
- The pointer arithmetic wraps modulo MAX_OUTSTANDING.
- Occupancy counter width is $clog2(MAX_OUTSTANDING)+1.

Decomposition:
- Package mem_bus_pkg:
  - master_id_t (1 bit), with constants MASTER_CPU=0 and MASTER_AUX=1.
  - bus_req_t struct grouping addr, write_data, byte_enable, write_req, read_req.
- Sub-module read_tag_fifo, parameterised by DEPTH and WIDTH:
  - Ports: push, push_data, pop, head, full, empty.
  - Registered pointers and count.

Test Plan:
1. Only m0 reads addr 0x10000000 with s_ready=1 -> s_read_req=1 and m0_ready=1 in the same cycle. A return of 0x00000013 two cycles later -> m0_read_data_valid=1 and m1_read_data_valid=0.
2. Both masters request every cycle with s_ready=1 -> grants alternate 0,1,0,1 starting from master 0 after reset.
3. m1 writes 0xDEADBEEF with byte_enable 0xF, s_ready=0 for 3 cycles, m0 also requesting -> s_* stays at the m1 values for all 4 cycles. Grant passes to m0 only after acceptance.
4. Four m0 reads accepted with no returns (MAX_OUTSTANDING=4), then an m1 read -> m1_ready=0 until a return pops the FIFO. An m1 write in the same state is accepted.
5. Interleaved accepted reads m0, m1, m0, then 3 returns -> valid strobes on m0, m1, m0 in that order.
6. s_read_data_valid pulse with an empty FIFO -> error=1 and stays set. Then reset_n low -> error=0, prio=0, FIFO empty.
